// File: rtl/serial_mag_comp_pkg.sv
// serial_mag_comp_pkg
//   Shared types for the bit-serial magnitude comparator sequencer.
//   - state_t      : sequencer states IDLE / CMP / DONE
//   - res_t        : 2-bit result code used by both the sticky register and
//                    the result register (NONE only exists before the first
//                    completed compare)
//   - res_to_flags : decodes a result code into the {eq, ls, gt} flag triple
package serial_mag_comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [1:0] res_t;

  localparam res_t RES_NONE = 2'd0;
  localparam res_t RES_EQ   = 2'd1;
  localparam res_t RES_LT   = 2'd2;
  localparam res_t RES_GT   = 2'd3;

  // Flag order is {eq, ls, gt}; NONE decodes to all zeros so the flags stay
  // low until the first result lands.
  function automatic logic [2:0] res_to_flags(input res_t r);
    logic [2:0] f;
    f = 3'b000;
    case (r)
      RES_EQ:  f = 3'b100;
      RES_LT:  f = 3'b010;
      RES_GT:  f = 3'b001;
      default: f = 3'b000;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/serial_mag_comp_ctrl_bit_cmp3.sv
// bit_cmp3
//   Combinational 1-bit three-way compare slice.
//   Ports:
//     a, b  in   operand bits
//     eq    out  a == b
//     ls    out  a <  b
//     gt    out  a >  b
module bit_cmp3 (
  input  logic a,
  input  logic b,
  output logic eq,
  output logic ls,
  output logic gt
);

  assign eq = ~(a ^ b);
  assign ls = ~a & b;
  assign gt = a & ~b;

endmodule

// File: rtl/serial_mag_comp_ctrl.sv
// serial_mag_comp_ctrl
//   Compares two WIDTH-bit unsigned operands one bit per cycle, MSB first,
//   through a single shared bit_cmp3 slice. A start/done handshake frames
//   each compare; the eq/lt/gt flags are held from one done to the next.
//   With EARLY_EXIT=1 the scan stops at the first differing bit, otherwise
//   all WIDTH bits are scanned and the first difference is kept in a sticky
//   register.
//   Ports:
//     clk        in   clock, rising edge
//     reset      in   synchronous active-high reset
//     start      in   request; accepted only while not busy (IDLE or DONE)
//     op_a/op_b  in   operands, sampled on the accept edge only
//     busy       out  high while scanning bits
//     done       out  one-cycle pulse, flags valid in that cycle
//     a_eq_b     out  A == B
//     a_ls_b     out  A <  B
//     a_gt_b     out  A >  B
//     bits_used  out  number of bit compares behind the current result
module serial_mag_comp_ctrl
  import serial_mag_comp_pkg::*;
#(
  parameter  int WIDTH      = 8,
  parameter  bit EARLY_EXIT = 1'b1,
  localparam int CW         = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             a_eq_b,
  output logic             a_ls_b,
  output logic             a_gt_b,
  output logic [CW-1:0]    bits_used
);

  localparam int IW = $clog2(WIDTH);

  state_t           state_q, next_state;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]    idx_q;
  logic [CW-1:0]    bits_used_q;
  res_t             sticky_q, sticky_next;
  res_t             result_q;

  logic accept;
  logic finish;
  logic bit_diff;
  logic slice_eq, slice_ls, slice_gt;

  // The one shared compare slice, fed by the currently selected bit pair.
  bit_cmp3 u_slice (
    .a  (a_q[idx_q]),
    .b  (b_q[idx_q]),
    .eq (slice_eq),
    .ls (slice_ls),
    .gt (slice_gt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= next_state;
  end

  // Next-state and control decode. The sticky value only ever moves away
  // from EQ once, so the first differing bit decides the outcome. In
  // early-exit mode the sticky is still EQ when the first difference shows
  // up, which lets sticky_next serve as the final result in both modes.
  always_comb begin
    next_state  = state_q;
    busy        = 1'b0;
    done        = 1'b0;
    accept      = 1'b0;
    finish      = 1'b0;
    bit_diff    = ~slice_eq;
    sticky_next = sticky_q;
    if (sticky_q == RES_EQ && bit_diff)
      sticky_next = slice_gt ? RES_GT : (slice_ls ? RES_LT : RES_EQ);
    case (state_q)
      IDLE: begin
        accept = start;
        if (start) next_state = CMP;
      end
      CMP: begin
        busy   = 1'b1;
        finish = (EARLY_EXIT && bit_diff) || (idx_q == '0);
        if (finish) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        accept     = start;
        next_state = start ? CMP : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand, index, sticky, counter and result registers. Operands are only
  // captured on accept, so op_a/op_b are free to change during a scan.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      bits_used_q <= '0;
      sticky_q    <= RES_EQ;
      result_q    <= RES_NONE;
    end else if (accept) begin
      a_q         <= op_a;
      b_q         <= op_b;
      idx_q       <= IW'(WIDTH - 1);
      bits_used_q <= '0;
      sticky_q    <= RES_EQ;
    end else if (state_q == CMP) begin
      bits_used_q <= bits_used_q + CW'(1);
      sticky_q    <= sticky_next;
      if (finish) result_q <= sticky_next;
      else        idx_q    <= idx_q - IW'(1);
    end
  end

  assign {a_eq_b, a_ls_b, a_gt_b} = res_to_flags(result_q);
  assign bits_used                = bits_used_q;

endmodule

// File: tb/tb_serial_mag_comp_ctrl.sv
// tb_serial_mag_comp_ctrl
//   Two instances share clock, reset and operands: dut_e scans with early
//   exit, dut_f always scans the full width. Each has its own start so the
//   two can be exercised independently against a plain-arithmetic model.
module tb_serial_mag_comp_ctrl;

  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start_e, start_f;
  logic [WIDTH-1:0] op_a, op_b;
  logic             busy_e, done_e, eq_e, ls_e, gt_e;
  logic             busy_f, done_f, eq_f, ls_f, gt_f;
  logic [CW-1:0]    bu_e, bu_f;

  int checks = 0;
  int errors = 0;
  logic [2:0] prev_e, prev_f;

  serial_mag_comp_ctrl #(.WIDTH(WIDTH), .EARLY_EXIT(1'b1)) dut_e (
    .clk(clk), .reset(reset), .start(start_e), .op_a(op_a), .op_b(op_b),
    .busy(busy_e), .done(done_e), .a_eq_b(eq_e), .a_ls_b(ls_e),
    .a_gt_b(gt_e), .bits_used(bu_e)
  );

  serial_mag_comp_ctrl #(.WIDTH(WIDTH), .EARLY_EXIT(1'b0)) dut_f (
    .clk(clk), .reset(reset), .start(start_f), .op_a(op_a), .op_b(op_b),
    .busy(busy_f), .done(done_f), .a_eq_b(eq_f), .a_ls_b(ls_f),
    .a_gt_b(gt_f), .bits_used(bu_f)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: flags from ordinary integer comparison; latency from the
  // position of the most significant set bit of a^b.
  function automatic void refModel(input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b, input bit full,
                                   output logic [2:0] flags, output int lat);
    logic [WIDTH-1:0] x;
    int k;
    x = a ^ b;
    k = WIDTH;
    for (int i = 0; i < WIDTH; i++) if (x[i]) k = WIDTH - i;
    if (a == b)     flags = 3'b100;
    else if (a < b) flags = 3'b010;
    else            flags = 3'b001;
    lat = (full || a == b) ? WIDTH + 1 : k + 1;
  endfunction

  function automatic logic [2:0] curFlags(input bit full);
    return full ? {eq_f, ls_f, gt_f} : {eq_e, ls_e, gt_e};
  endfunction

  task automatic setStart(input bit full, input logic v);
    if (full) start_f = v;
    else      start_e = v;
  endtask

  // One start pulse, optional stray start and operand scrambling mid-scan,
  // then checks latency, flags, bits_used and the return to idle.
  task automatic applyStimulus(input bit full, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input bit poke);
    logic [2:0] exp_flags, prev;
    int exp_lat, cnt;
    bit seen, pulsed;
    refModel(a, b, full, exp_flags, exp_lat);
    prev   = full ? prev_f : prev_e;
    op_a   = a;
    op_b   = b;
    setStart(full, 1'b1);
    cnt    = 0;
    seen   = 0;
    pulsed = 0;
    while (!seen && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
      if (cnt == 1) setStart(full, 1'b0);
      if (pulsed) begin
        setStart(full, 1'b0);
        pulsed = 0;
      end
      if (full ? done_f : done_e) seen = 1;
      else if (cnt == 2 && poke && exp_lat > 3) begin
        checkOutput("busy_mid", 32'(full ? busy_f : busy_e), 32'd1);
        checkOutput("flags_hold", 32'(curFlags(full)), 32'(prev));
        op_a   = WIDTH'($urandom);
        op_b   = WIDTH'($urandom);
        setStart(full, 1'b1);
        pulsed = 1;
      end
    end
    checkOutput(full ? "lat_f" : "lat_e", seen ? cnt : 0, exp_lat);
    checkOutput(full ? "flags_f" : "flags_e", 32'(curFlags(full)),
                32'(exp_flags));
    checkOutput(full ? "bits_f" : "bits_e", 32'(full ? bu_f : bu_e),
                exp_lat - 1);
    if (full) prev_f = exp_flags;
    else      prev_e = exp_flags;
    @(posedge clk); #1;
    checkOutput("idle_after", 32'({full ? busy_f : busy_e,
                                   full ? done_f : done_e}), 32'd0);
  endtask

  function automatic logic [WIDTH-1:0] pickB(input logic [WIDTH-1:0] a);
    int mode;
    mode = $urandom_range(0, 3);
    if (mode == 0) return a;
    if (mode == 1) return a ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
    return WIDTH'($urandom);
  endfunction

  // Main sequence: reset, directed cases, back-to-back, reset abort, random.
  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic [WIDTH-1:0] ba [4];
    logic [WIDTH-1:0] bb [4];
    logic [2:0] ef;
    int el, cnt;
    bit seen;

    reset   = 1'b1;
    start_e = 1'b1;
    start_f = 1'b1;
    op_a    = 8'hFF;
    op_b    = 8'h00;
    prev_e  = 3'b000;
    prev_f  = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_e", 32'({busy_e, done_e, eq_e, ls_e, gt_e, bu_e}), 32'd0);
    checkOutput("rst_f", 32'({busy_f, done_f, eq_f, ls_f, gt_f, bu_f}), 32'd0);
    start_e = 1'b0;
    start_f = 1'b0;
    reset   = 1'b0;
    @(posedge clk); #1;

    $display("[TB] directed cases");
    applyStimulus(0, 8'hA5, 8'hA5, 0);
    applyStimulus(0, 8'h80, 8'h7F, 0);
    applyStimulus(0, 8'h12, 8'h13, 1);
    applyStimulus(1, 8'h80, 8'h7F, 1);
    applyStimulus(1, 8'hA5, 8'hA5, 0);
    applyStimulus(1, 8'h00, 8'h01, 0);

    // Start held high: each done is followed directly by the next scan.
    $display("[TB] back-to-back");
    ba[0] = 8'h40; bb[0] = 8'h00;
    ba[1] = 8'h0F; bb[1] = 8'h1F;
    ba[2] = 8'h33; bb[2] = 8'h33;
    ba[3] = 8'hC1; bb[3] = 8'hC0;
    op_a    = ba[0];
    op_b    = bb[0];
    start_e = 1'b1;
    for (int n = 0; n < 4; n++) begin
      refModel(ba[n], bb[n], 0, ef, el);
      cnt  = 0;
      seen = 0;
      while (!seen && cnt < 40) begin
        @(posedge clk); #1;
        cnt++;
        if (cnt == 1) checkOutput("b2b_busy", 32'(busy_e), 32'd1);
        if (done_e) seen = 1;
      end
      checkOutput("b2b_lat", seen ? cnt : 0, el);
      checkOutput("b2b_flags", 32'({eq_e, ls_e, gt_e}), 32'(ef));
      prev_e = ef;
      if (n < 3) begin
        op_a = ba[n+1];
        op_b = bb[n+1];
      end else begin
        start_e = 1'b0;
      end
    end
    @(posedge clk); #1;

    // Reset in the middle of a scan discards everything.
    $display("[TB] reset abort");
    op_a    = 8'h12;
    op_b    = 8'h13;
    start_e = 1'b1;
    @(posedge clk); #1;
    start_e = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("abort_e", 32'({busy_e, done_e, eq_e, ls_e, gt_e, bu_e}), 32'd0);
    checkOutput("abort_f_flags", 32'({eq_f, ls_f, gt_f}), 32'd0);
    prev_e = 3'b000;
    prev_f = 3'b000;
    @(posedge clk); #1;
    checkOutput("abort_no_done", 32'(done_e), 32'd0);
    applyStimulus(0, 8'h5A, 8'h3C, 1);

    $display("[TB] random cases");
    for (int i = 0; i < 24; i++) begin
      ra = WIDTH'($urandom);
      rb = pickB(ra);
      applyStimulus(i[0], ra, rb, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
